// File: rtl/axi_rd_arbiter_pkg.sv
// rtl/axi_rd_arbiter_pkg.sv - shared types and AXI encodings for the read arbiter
// Purpose: AR FSM state encoding and the AXI burst/size/cache/prot values the
//          arbiter drives or resets to.
// Ports:   none (package).
package axi_rd_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [2:0] AXI_SIZE_1B     = 3'd0;
  localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI4 read-address/read-data bus bundle
// Purpose: groups the shared AXI4 AR and R channel signals of the arbiter's
//          master port.
// Ports:   none; modport master (arbiter side) drives AR fields, arvalid and
//          rready; modport slave (interconnect/DDR side) drives arready and
//          the R fields.
interface axi_rd_arbiter_if #(
  parameter int ID_W = 8,
  parameter int AW   = 32,
  parameter int DW   = 32
);

  logic [ID_W-1:0] arid;
  logic [AW-1:0]   araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/rd_arb_tag_fifo.sv
// rtl/rd_arb_tag_fifo.sv - in-order tag FIFO recording which requester owns each burst
// Purpose: synchronous FIFO of requester indices, one entry per accepted AR,
//          popped when the matching R burst ends.
// Ports:   clk, rst_n (async active-low); push/push_data write an entry;
//          pop drops the head; head is the oldest entry; full, empty and
//          count report occupancy (0..DEPTH).
module rd_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  // Gate locally so a misbehaving caller cannot corrupt the occupancy.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop_ok)      cnt <= cnt + CNT_W'(1);
      else if (pop_ok && !push_ok) cnt <= cnt - CNT_W'(1);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - shares one AXI4 read master between NUM_REQ fetch engines
// Purpose: arbitrates per-requester AR requests onto one AXI4 AR channel,
//          tags each grant in an in-order FIFO and steers R bursts back to
//          their owner. Relies on in-order R return (single ARID).
// Config:  RD_ARB_FIXED_PRIO_EN defined -> fixed priority (lowest index wins);
//          undefined -> round-robin starting after the last winner.
// Ports:   m_axi_aclk, m_axi_aresetn (async active-low);
//          s_araddr/s_arlen/s_arsize/s_arburst/s_arvalid/s_arready per-requester
//          AR, packed req i at [i*W +: W]; s_rdata/s_rresp/s_rlast broadcast R;
//          s_rvalid/s_rready per-requester R handshake; m_axi master port
//          (AXI4 AR+R); outstanding = tag FIFO occupancy; err_unexp_r sticky
//          flag for an R beat arriving with nothing outstanding.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ            = 2,
  parameter int IDX_W              = 1,
  parameter int MAX_OUTST          = 4,
  parameter int C_M_AXI_ID_WIDTH   = 8,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int ARID_VALUE         = 0
) (
  input  logic                                  m_axi_aclk,
  input  logic                                  m_axi_aresetn,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ*8-1:0]                  s_arlen,
  input  logic [NUM_REQ*3-1:0]                  s_arsize,
  input  logic [NUM_REQ*2-1:0]                  s_arburst,
  input  logic [NUM_REQ-1:0]                    s_arvalid,
  output logic [NUM_REQ-1:0]                    s_arready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         s_rdata,
  output logic [1:0]                            s_rresp,
  output logic                                  s_rlast,
  output logic [NUM_REQ-1:0]                    s_rvalid,
  input  logic [NUM_REQ-1:0]                    s_rready,
  axi_rd_arbiter_if.master                      m_axi,
  output logic [$clog2(MAX_OUTST):0]            outstanding,
  output logic                                  err_unexp_r
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;

  ar_state_t        state;
  ar_state_t        state_nxt;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] head;
  logic             found;
  logic             grant;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic [AW-1:0]    sel_addr;
  logic [7:0]       sel_len;
  logic [2:0]       sel_size;
  logic [1:0]       sel_burst;

`ifdef RD_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (s_arvalid[i]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;

  // Search order is rr_ptr+1, rr_ptr+2, ... wrapping; the first requester hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && s_arvalid[i] && (((int'(rr_ptr) + k) % NUM_REQ) == i)) begin
          winner = IDX_W'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // Reset to the last index so requester 0 is searched first.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) rr_ptr <= IDX_W'(NUM_REQ - 1);
    else if (grant)     rr_ptr <= winner;
  end
`endif

  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_addr  = s_araddr[i*AW +: AW];
        sel_len   = s_arlen[i*8 +: 8];
        sel_size  = s_arsize[i*3 +: 3];
        sel_burst = s_arburst[i*2 +: 2];
      end
    end
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  // Grants are only taken in IDLE, so one AR is in flight on the master
  // port at a time and its fields stay stable until arready.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    s_arready = '0;
    case (state)
      IDLE: begin
        if (found && !fifo_full) begin
          grant             = 1'b1;
          s_arready[winner] = 1'b1;
          state_nxt         = ISSUE;
        end
      end
      ISSUE: begin
        if (m_axi.arready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      m_axi.araddr  <= '0;
      m_axi.arlen   <= '0;
      m_axi.arsize  <= '0;
      m_axi.arburst <= AXI_BURST_INCR;
    end else if (grant) begin
      m_axi.araddr  <= sel_addr;
      m_axi.arlen   <= sel_len;
      m_axi.arsize  <= sel_size;
      m_axi.arburst <= sel_burst;
    end
  end

  assign m_axi.arvalid = (state == ISSUE);
  assign m_axi.arid    = C_M_AXI_ID_WIDTH'(ARID_VALUE);
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_CACHE_NONE;
  assign m_axi.arprot  = AXI_PROT_NONE;

  rd_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk       (m_axi_aclk),
    .rst_n     (m_axi_aresetn),
    .push      (grant),
    .push_data (winner),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  // R steering is purely combinational: the FIFO head names the owner of the
  // burst currently returning, and the burst retires on its last beat.
  assign m_axi.rready = !fifo_empty && s_rready[head];
  assign pop          = m_axi.rvalid && m_axi.rready && m_axi.rlast;

  always_comb begin
    s_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head == IDX_W'(i)) s_rvalid[i] = m_axi.rvalid && !fifo_empty;
    end
  end

  assign s_rdata = m_axi.rdata;
  assign s_rresp = m_axi.rresp;
  assign s_rlast = m_axi.rlast;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn)                 err_unexp_r <= 1'b0;
    else if (m_axi.rvalid && fifo_empty) err_unexp_r <= 1'b1;
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed self-checking bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [1:0]  s_arvalid;
  logic [1:0]  s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [1:0]  s_rvalid;
  logic [1:0]  s_rready;
  logic [2:0]  outstanding;
  logic        err_unexp_r;
  int          checks = 0;
  int          failures = 0;

  axi_rd_arbiter_if #(.ID_W(8), .AW(32), .DW(32)) m_axi ();

  axi_rd_arbiter #(
    .NUM_REQ(2), .IDX_W(1), .MAX_OUTST(4), .C_M_AXI_ID_WIDTH(8),
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .ARID_VALUE(0)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_axi(m_axi), .outstanding(outstanding), .err_unexp_r(err_unexp_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arvalid = '0; s_rready = '0;
    m_axi.arready = 1'b0; m_axi.rid = '0; m_axi.rdata = '0;
    m_axi.rresp = '0; m_axi.rlast = 1'b0; m_axi.rvalid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int r, input logic [31:0] addr, input logic [7:0] len);
    s_araddr[r*32 +: 32] = addr;
    s_arlen[r*8 +: 8]    = len;
    s_arsize[r*3 +: 3]   = 3'd2;
    s_arburst[r*2 +: 2]  = 2'b01;
  endtask

  // Drives one complete AR from requester r starting in IDLE; ends back in IDLE.
  task automatic issue_one(input int r, input logic [31:0] addr);
    set_req(r, addr, 8'd0);
    s_arvalid = '0;
    s_arvalid[r] = 1'b1;
    m_axi.arready = 1'b1;
    tick();
    s_arvalid = '0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_axi.arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0b exp=0", m_axi.arvalid); end
    checks++; if (m_axi.araddr !== 32'h0) begin failures++; $display("FAIL reset_araddr got=%h exp=0", m_axi.araddr); end
    checks++; if (m_axi.arburst !== 2'b01) begin failures++; $display("FAIL reset_arburst got=%b exp=01", m_axi.arburst); end
    checks++; if (m_axi.arid !== 8'h00) begin failures++; $display("FAIL reset_arid got=%h exp=00", m_axi.arid); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    checks++; if (err_unexp_r !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err_unexp_r); end
    rst_n = 1'b1;
    s_arvalid = 2'b11;
    #1;
    checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL reset_first_winner got=%b exp=01", s_arready); end
    s_arvalid = 2'b00;
  endtask

  task automatic test_single_burst();
    tick();
    set_req(0, 32'h1000, 8'd3);
    s_arvalid = 2'b01;
    #1;
    checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL single_arready got=%b exp=01", s_arready); end
    tick();
    s_arvalid = 2'b00;
    m_axi.arready = 1'b1;
    checks++; if (m_axi.arvalid !== 1'b1) begin failures++; $display("FAIL single_arvalid got=%0b exp=1", m_axi.arvalid); end
    checks++; if (m_axi.araddr !== 32'h1000) begin failures++; $display("FAIL single_araddr got=%h exp=1000", m_axi.araddr); end
    checks++; if (m_axi.arlen !== 8'd3) begin failures++; $display("FAIL single_arlen got=%0d exp=3", m_axi.arlen); end
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_outst got=%0d exp=1", outstanding); end
    tick();
    m_axi.arready = 1'b0;
    checks++; if (m_axi.arvalid !== 1'b0) begin failures++; $display("FAIL single_arvalid_drop got=%0b exp=0", m_axi.arvalid); end
    s_rready = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_axi.rvalid = 1'b1;
      m_axi.rdata  = 32'hA0 + b;
      m_axi.rlast  = (b == 3);
      #1;
      checks++;
      if (s_rvalid !== 2'b01 || s_rdata !== 32'hA0 + b || m_axi.rready !== 1'b1) begin
        failures++;
        $display("FAIL single_beat%0d rvalid=%b rdata=%h rready=%0b exp 01/%h/1", b, s_rvalid, s_rdata, m_axi.rready, 32'hA0 + b);
      end
      tick();
    end
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL single_pop got=%0d exp=0", outstanding); end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] exp;
    apply_reset();
    m_axi.arready = 1'b1;
    set_req(0, 32'h2000, 8'd1);
    set_req(1, 32'h3000, 8'd1);
    s_arvalid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
`ifdef RD_ARB_FIXED_PRIO_EN
      exp = 2'b01;
`else
      exp = (g % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++; if (s_arready !== exp) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", g, s_arready, exp); end
      tick();
      checks++;
      if (m_axi.araddr !== ((exp == 2'b01) ? 32'h2000 : 32'h3000)) begin
        failures++; $display("FAIL rr_addr%0d got=%h exp=%h", g, m_axi.araddr, (exp == 2'b01) ? 32'h2000 : 32'h3000);
      end
      tick();
    end
    s_arvalid = 2'b00;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL rr_outst got=%0d exp=4", outstanding); end
  endtask

  task automatic test_full_backpressure();
    apply_reset();
    for (int k = 0; k < 4; k++) issue_one(1, 32'h7000 + k * 32'h40);
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_outst got=%0d exp=4", outstanding); end
    s_arvalid = 2'b10;
    m_axi.arready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (s_arready !== 2'b00 || m_axi.arvalid !== 1'b0) begin
        failures++; $display("FAIL full_block%0d arready=%b arvalid=%0b exp 00/0", c, s_arready, m_axi.arvalid);
      end
      tick();
    end
    m_axi.rvalid = 1'b1;
    m_axi.rlast  = 1'b1;
    s_rready = 2'b10;
    #1;
    checks++; if (s_rvalid !== 2'b10) begin failures++; $display("FAIL full_rvalid got=%b exp=10", s_rvalid); end
    checks++; if (s_arready !== 2'b00) begin failures++; $display("FAIL full_pop_cycle_arready got=%b exp=00", s_arready); end
    tick();
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL full_after_pop got=%0d exp=3", outstanding); end
    checks++; if (s_arready !== 2'b10) begin failures++; $display("FAIL full_reopen got=%b exp=10", s_arready); end
    tick();
    s_arvalid = 2'b00;
    checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_refill got=%0d exp=4", outstanding); end
    tick();
  endtask

  task automatic test_push_pop_same_cycle();
    apply_reset();
    issue_one(0, 32'h4000);
    issue_one(1, 32'h5000);
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL pp_setup got=%0d exp=2", outstanding); end
    set_req(0, 32'h6000, 8'd0);
    s_arvalid = 2'b01;
    m_axi.rvalid = 1'b1;
    m_axi.rlast  = 1'b1;
    m_axi.rdata  = 32'hB0;
    s_rready = 2'b11;
    #1;
    checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL pp_arready got=%b exp=01", s_arready); end
    checks++; if (s_rvalid !== 2'b01) begin failures++; $display("FAIL pp_head0 got=%b exp=01", s_rvalid); end
    tick();
    s_arvalid = 2'b00;
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL pp_outst got=%0d exp=2", outstanding); end
    checks++; if (s_rvalid !== 2'b10) begin failures++; $display("FAIL pp_head1 got=%b exp=10", s_rvalid); end
    tick();
    checks++; if (s_rvalid !== 2'b01) begin failures++; $display("FAIL pp_head2 got=%b exp=01", s_rvalid); end
    checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL pp_outst1 got=%0d exp=1", outstanding); end
    tick();
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL pp_drain got=%0d exp=0", outstanding); end
  endtask

  task automatic test_unexpected_r();
    apply_reset();
    s_rready = 2'b11;
    m_axi.rvalid = 1'b1;
    m_axi.rlast  = 1'b1;
    #1;
    checks++; if (m_axi.rready !== 1'b0) begin failures++; $display("FAIL unexp_rready got=%0b exp=0", m_axi.rready); end
    checks++; if (s_rvalid !== 2'b00) begin failures++; $display("FAIL unexp_srvalid got=%b exp=00", s_rvalid); end
    tick();
    m_axi.rvalid = 1'b0;
    m_axi.rlast  = 1'b0;
    checks++; if (err_unexp_r !== 1'b1) begin failures++; $display("FAIL unexp_err_set got=%0b exp=1", err_unexp_r); end
    tick();
    tick();
    checks++; if (err_unexp_r !== 1'b1) begin failures++; $display("FAIL unexp_err_sticky got=%0b exp=1", err_unexp_r); end
  endtask

  task automatic test_async_reset();
    issue_one(0, 32'h8000);
    set_req(0, 32'h9000, 8'd0);
    s_arvalid = 2'b01;
    m_axi.arready = 1'b0;
    tick();
    s_arvalid = 2'b00;
    checks++; if (m_axi.arvalid !== 1'b1) begin failures++; $display("FAIL ar_issue got=%0b exp=1", m_axi.arvalid); end
    checks++; if (outstanding !== 3'd2) begin failures++; $display("FAIL ar_outst got=%0d exp=2", outstanding); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (m_axi.arvalid !== 1'b0) begin failures++; $display("FAIL ar_async_arvalid got=%0b exp=0", m_axi.arvalid); end
    checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL ar_async_outst got=%0d exp=0", outstanding); end
    checks++; if (err_unexp_r !== 1'b0) begin failures++; $display("FAIL ar_async_err got=%0b exp=0", err_unexp_r); end
    #1;
    rst_n = 1'b1;
    set_req(0, 32'hC000, 8'd0);
    set_req(1, 32'hD000, 8'd0);
    s_arvalid = 2'b11;
    #1;
    checks++; if (s_arready !== 2'b01) begin failures++; $display("FAIL ar_req0_wins got=%b exp=01", s_arready); end
    tick();
    s_arvalid = 2'b00;
    m_axi.arready = 1'b1;
    checks++; if (m_axi.araddr !== 32'hC000) begin failures++; $display("FAIL ar_post_addr got=%h exp=c000", m_axi.araddr); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_rr_alternate();
    test_full_backpressure();
    test_push_pop_same_cycle();
    test_unexpected_r();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
